mult_req_issuer: RTL and testbench

MULT_REQ_ISSUER -- requirements
Module: mult_req_issuer

---
 rtl/mult_req_issuer_pkg.sv | 28 ++
 rtl/mult_req_issuer_if.sv | 25 ++
 rtl/mult_req_issuer.sv | 144 ++++++++++++++
 tb/tb_mult_req_issuer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_req_issuer_pkg.sv
// Shared types for mult_req_issuer: FSM state encoding, the response record,
// the default wait limit and the even-parity helper.
package mult_issuer_pkg;

    localparam int DEFAULT_TIMEOUT_CYC = 255;

    typedef enum logic [2:0] {
        IDLE,
        REQ_HI,
        ACK_LO,
        RES_WAIT,
        RES_LO,
        RESP
    } state_e;

    typedef struct packed {
        logic [31:0] result;
        logic        arg_err;
        logic        res_par_err;
        logic        timeout;
    } resp_t;

    // Even parity bit: XOR of every bit, so the word plus parity has an even count of ones.
    function automatic logic even_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mult_req_issuer_if.sv
// Four-phase request/result link between the issuer (master) and a multiplier (slave).
interface mult_req_issuer_if;

    logic               req;
    logic signed [15:0] arg_a;
    logic signed [15:0] arg_b;
    logic               arg_a_parity;
    logic               arg_b_parity;
    logic               ack;
    logic signed [31:0] result;
    logic               result_parity;
    logic               result_rdy;
    logic               arg_parity_error;

    modport master (
        output req, arg_a, arg_b, arg_a_parity, arg_b_parity,
        input  ack, result, result_parity, result_rdy, arg_parity_error
    );

    modport slave (
        input  req, arg_a, arg_b, arg_a_parity, arg_b_parity,
        output ack, result, result_parity, result_rdy, arg_parity_error
    );

endinterface

// File: rtl/mult_req_issuer.sv
// Issues one operand pair at a time to a multiplier over a four-phase handshake and
// returns the product with status flags. Define MULT_PARITY_INJECT_EN for parity injection.
module mult_req_issuer
    import mult_issuer_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_a,
    input  logic signed [15:0] in_b,
`ifdef MULT_PARITY_INJECT_EN
    input  logic               inj_a,
    input  logic               inj_b,
`endif
    mult_req_issuer_if.master  mult,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
    output logic               out_arg_err,
    output logic               out_res_par_err,
    output logic               out_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               req_q;
    logic signed [15:0] arg_a_q;
    logic signed [15:0] arg_b_q;
    logic               par_a_q;
    logic               par_b_q;
    logic               in_ready_q;
    logic               out_valid_q;
    resp_t              resp_q;

    logic               par_a_d;
    logic               par_b_d;
    logic               waiting;
    logic               advance;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        par_a_d = even_parity({16'h0000, in_a});
        par_b_d = even_parity({16'h0000, in_b});
`ifdef MULT_PARITY_INJECT_EN
        par_a_d = par_a_d ^ inj_a;
        par_b_d = par_b_d ^ inj_b;
`endif
        waiting = 1'b1;
        advance = 1'b0;
        case (state_q)
            REQ_HI:   advance = mult.ack;
            ACK_LO:   advance = !mult.ack;
            RES_WAIT: advance = mult.result_rdy;
            RES_LO:   advance = !mult.result_rdy;
            default:  waiting = 1'b0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            arg_a_q     <= '0;
            arg_b_q     <= '0;
            par_a_q     <= 1'b0;
            par_b_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            resp_q      <= '0;
        end else if (waiting && !advance) begin
            // A stalled handshake phase gives up after TIMEOUT_CYC cycles with a zeroed product.
            if (cnt_q == CNT_LAST) begin
                req_q       <= 1'b0;
                resp_q      <= '{result: 32'h0, arg_err: 1'b0, res_par_err: 1'b0, timeout: 1'b1};
                out_valid_q <= 1'b1;
                cnt_q       <= '0;
                state_q     <= RESP;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        arg_a_q    <= in_a;
                        arg_b_q    <= in_b;
                        par_a_q    <= par_a_d;
                        par_b_q    <= par_b_d;
                        req_q      <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    req_q   <= 1'b0;
                    state_q <= ACK_LO;
                end
                ACK_LO: state_q <= RES_WAIT;
                RES_WAIT: begin
                    resp_q.result      <= mult.result;
                    resp_q.arg_err     <= mult.arg_parity_error;
                    resp_q.res_par_err <= even_parity(mult.result) != mult.result_parity;
                    resp_q.timeout     <= 1'b0;
                    state_q            <= RES_LO;
                end
                RES_LO: begin
                    out_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready          = in_ready_q;
    assign mult.req          = req_q;
    assign mult.arg_a        = arg_a_q;
    assign mult.arg_b        = arg_b_q;
    assign mult.arg_a_parity = par_a_q;
    assign mult.arg_b_parity = par_b_q;
    assign out_valid         = out_valid_q;
    assign out_result        = resp_q.result;
    assign out_arg_err       = resp_q.arg_err;
    assign out_res_par_err   = resp_q.res_par_err;
    assign out_timeout       = resp_q.timeout;

endmodule

// File: tb/tb_mult_req_issuer.sv
// Scoreboard bench for mult_req_issuer: a behavioural multiplier answers the handshake,
// the driver queues expected responses and a monitor pops and compares them.
module tb_mult_req_issuer;

    localparam int TO_CYC = 8;

    localparam int M_NORM   = 0;
    localparam int M_FLIP   = 1;
    localparam int M_ARGERR = 2;
    localparam int M_EARLY  = 3;
    localparam int M_NOACK  = 4;
    localparam int M_HOLD   = 5;

    typedef struct {
        logic [31:0] result;
        logic        arg_err;
        logic        res_par_err;
        logic        timeout;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_a;
    logic signed [15:0] in_b;
    logic               inj_a;
    logic               inj_b;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_result;
    logic               out_arg_err;
    logic               out_res_par_err;
    logic               out_timeout;

    mult_req_issuer_if mb ();

    mult_req_issuer #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_a            (in_a),
        .in_b            (in_b),
`ifdef MULT_PARITY_INJECT_EN
        .inj_a           (inj_a),
        .inj_b           (inj_b),
`endif
        .mult            (mb),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_arg_err     (out_arg_err),
        .out_res_par_err (out_res_par_err),
        .out_timeout     (out_timeout)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   resp_count = 0;
    int   exp_count = 0;
    exp_t exp_q[$];

    int                 mode = M_NORM;
    logic signed [15:0] cur_a, cur_b;
    logic               cur_pa, cur_pb;
    bit                 held = 1'b0;
    bit                 stall_req = 1'b0;
    bit                 stall_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: signed 16x16 product plus flags derived from what the multiplier was told to do.
    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                        input int m, input bit ia, input bit ib, input bit push);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_send", {31'h0, in_ready}, 32'h1);
        mode   = m;
        cur_a  = a;
        cur_b  = b;
        cur_pa = (^a) ^ ia;
        cur_pb = (^b) ^ ib;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        inj_a    = ia;
        inj_b    = ib;
        @(negedge clk);
        in_valid = 1'b0;
        inj_a    = 1'b0;
        inj_b    = 1'b0;
        if (push) begin
            if (m == M_NOACK) begin
                e = '{result: 32'h0, arg_err: 1'b0, res_par_err: 1'b0, timeout: 1'b1};
            end else begin
                e.result      = 32'(int'(a) * int'(b));
                e.arg_err     = (m == M_ARGERR) || ia || ib;
                e.res_par_err = (m == M_FLIP);
                e.timeout     = 1'b0;
            end
            exp_q.push_back(e);
            exp_count++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && in_ready === 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_to_idle", {31'h0, (n < 400)}, 32'h1);
    endtask

    // Behavioural multiplier: four-phase ack, then result_rdy with optionally corrupted parity.
    initial begin : multiplier_model
        int                 m;
        logic signed [31:0] r;
        mb.ack = 1'b0;
        mb.result_rdy = 1'b0;
        mb.result = '0;
        mb.result_parity = 1'b0;
        mb.arg_parity_error = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mb.req === 1'b1 && rst === 1'b0) begin
                m    = mode;
                held = 1'b0;
                check("arg_a", 32'(mb.arg_a), 32'(cur_a));
                check("arg_b", 32'(mb.arg_b), 32'(cur_b));
                check("arg_a_parity", {31'h0, mb.arg_a_parity}, {31'h0, cur_pa});
                check("arg_b_parity", {31'h0, mb.arg_b_parity}, {31'h0, cur_pb});
                if (m == M_NOACK) begin
                    while (mb.req === 1'b1) begin @(posedge clk); #1; end
                end else begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    r = mb.arg_a * mb.arg_b;
                    mb.result = r;
                    mb.result_parity = (^r) ^ (m == M_FLIP);
                    mb.arg_parity_error = ((^mb.arg_a) != mb.arg_a_parity) ||
                                          ((^mb.arg_b) != mb.arg_b_parity) || (m == M_ARGERR);
                    if (m == M_EARLY) mb.result_rdy = 1'b1;
                    mb.ack = 1'b1;
                    while (mb.req === 1'b1) begin @(posedge clk); #1; end
                    repeat ($urandom_range(0, 1)) @(posedge clk);
                    #1;
                    mb.ack = 1'b0;
                    if (m == M_HOLD) begin
                        held = 1'b1;
                    end else begin
                        if (m != M_EARLY) begin
                            repeat ($urandom_range(0, 2)) @(posedge clk);
                            #1;
                            mb.result_rdy = 1'b1;
                        end
                        repeat ($urandom_range(2, 3)) @(posedge clk);
                        #1;
                        mb.result_rdy = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: random out_ready backpressure, scoreboard pop on each accepted response.
    initial begin : monitor
        exp_t        e;
        logic [31:0] s_res;
        logic [2:0]  s_flags;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                out_ready = 1'b0;
            end else begin
                if (out_valid === 1'b1 && stall_req && !stall_done) begin
                    stall_done = 1'b1;
                    out_ready  = 1'b0;
                    s_res   = out_result;
                    s_flags = {out_arg_err, out_res_par_err, out_timeout};
                    for (int i = 0; i < 10; i++) begin
                        @(negedge clk);
                        check("stall_out_valid", {31'h0, out_valid}, 32'h1);
                        check("stall_result", out_result, s_res);
                        check("stall_flags", {29'h0, out_arg_err, out_res_par_err, out_timeout},
                              {29'h0, s_flags});
                        check("stall_in_ready", {31'h0, in_ready}, 32'h0);
                    end
                end
                out_ready = ($urandom_range(0, 3) != 0);
                if (out_valid === 1'b1 && out_ready) begin
                    check("req_low_in_resp", {31'h0, mb.req}, 32'h0);
                    check("in_ready_low_in_resp", {31'h0, in_ready}, 32'h0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_response: got result %h, expected no response", out_result);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_result", out_result, e.result);
                        check("out_arg_err", {31'h0, out_arg_err}, {31'h0, e.arg_err});
                        check("out_res_par_err", {31'h0, out_res_par_err}, {31'h0, e.res_par_err});
                        check("out_timeout", {31'h0, out_timeout}, {31'h0, e.timeout});
                    end
                    resp_count++;
                end
            end
        end
    end

    initial begin : driver
        int n;
        int m;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        inj_a = 1'b0;
        inj_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_req", {31'h0, mb.req}, 32'h0);
        check("rst_args", {mb.arg_a, mb.arg_b}, 32'h0);
        check("rst_parities", {30'h0, mb.arg_a_parity, mb.arg_b_parity}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_flags", {29'h0, out_arg_err, out_res_par_err, out_timeout}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {31'h0, in_ready}, 32'h1);

        send(16'sd3, -16'sd4, M_NORM, 1'b0, 1'b0, 1'b1);
        send(16'sd7, 16'sd5, M_FLIP, 1'b0, 1'b0, 1'b1);
        send(16'sd6, -16'sd9, M_ARGERR, 1'b0, 1'b0, 1'b1);
`ifdef MULT_PARITY_INJECT_EN
        send(16'sh0001, 16'sd2, M_NORM, 1'b1, 1'b0, 1'b1);
`endif
        send(16'sd100, 16'sd200, M_EARLY, 1'b0, 1'b0, 1'b1);
        wait_idle();

        stall_req = 1'b1;
        send(-16'sd32768, -16'sd32768, M_NORM, 1'b0, 1'b0, 1'b1);
        wait_idle();
        check("stall_exercised", {31'h0, stall_done}, 32'h1);
        send(16'sd32767, -16'sd32768, M_NORM, 1'b0, 1'b0, 1'b1);

        send(16'sd5, 16'sd5, M_NOACK, 1'b0, 1'b0, 1'b1);
        wait_idle();

        // Abandon a transaction while the multiplier withholds its result.
        send(16'sd9, 16'sd9, M_HOLD, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!held && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached", {31'h0, held}, 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_req", {31'h0, mb.req}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 2 * TO_CYC; i++) begin
            @(negedge clk);
            check("post_rst_no_response", {31'h0, out_valid}, 32'h0);
        end
        send(16'sd2, 16'sd2, M_NORM, 1'b0, 1'b0, 1'b1);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(0, 3);
`ifdef MULT_PARITY_INJECT_EN
            send(16'($urandom), 16'($urandom), m, 1'($urandom), 1'($urandom), 1'b1);
`else
            send(16'($urandom), 16'($urandom), m, 1'b0, 1'b0, 1'b1);
`endif
        end
        wait_idle();
        check("response_count", resp_count, exp_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
